irq_controller: RTL and testbench

Memory-mapped interrupt controller that drives the pipeline core's `I_Req` input and consumes its `IACK` output. It synchronises and edge-detects up to `NUM_SRC` external sources, keeps pending and enable state, selects the lowest-index enabled pending source, and runs the request/acknowledge handshake with the core. It is also a responder on the core's data-memory bus (`Data_addr`/`Wdata`/`we`/`Rdata`), so software can claim, clear and end service of interrupts.

---
 rtl/irq_controller.sv | 150 +++++++++++++++
 tb/tb_irq_controller.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: synchronised edge capture, lowest-index priority, I_Req/IACK handshake.
// Define IRQC_LEVEL_EN to add the MODE register and per-source level-sensitive capture.
module irq_controller #(
  parameter int          NUM_SRC   = 8,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [31:0]        Data_addr,
  input  logic [31:0]        Wdata,
  input  logic [3:0]         we,
  output logic [31:0]        Rdata,
  output logic               sel,
  output logic               I_Req,
  input  logic               IACK,
  output logic [4:0]         irq_id
);

  typedef enum logic [1:0] {IDLE, REQ, ACKLOW, SERVICE} state_t;

  state_t state, next_state;

  logic [NUM_SRC-1:0] sync1, sync2, sync_prev, edge_hit;
  logic [NUM_SRC-1:0] pending, enable, pending_next;
  logic [NUM_SRC-1:0] wmask, w1c_mask, claim_mask, mode;
  logic [31:0]        lane_mask, claim_word, mode_word;
  logic [2:0]         offset;
  logic               wr, eoi, take, win_valid;
  logic [4:0]         win_idx;

  assign sel       = (Data_addr[31:5] == BASE_ADDR[31:5]);
  assign offset    = Data_addr[4:2];
  assign wr        = sel && (we != 4'b0000);
  assign eoi       = wr && (offset == 3'd3);
  assign lane_mask = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
  assign wmask     = Wdata[NUM_SRC-1:0] & lane_mask[NUM_SRC-1:0];
  assign w1c_mask  = (wr && (offset == 3'd0)) ? wmask : '0;
  assign take      = (state == REQ) && IACK && win_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1     <= '0;
      sync2     <= '0;
      sync_prev <= '0;
      edge_hit  <= '0;
    end else begin
      sync1     <= irq_src;
      sync2     <= sync1;
      sync_prev <= sync2;
      edge_hit  <= sync2 & ~sync_prev;
    end
  end

`ifdef IRQC_LEVEL_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      mode <= '0;
    else if (wr && (offset == 3'd4))
      mode <= (mode & ~lane_mask[NUM_SRC-1:0]) | wmask;
  end
`else
  assign mode = '0;
`endif
  assign mode_word = 32'(mode);

  // Descending scan so the lowest enabled pending index is the one left standing.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pending[i] && enable[i]) begin
        win_valid = 1'b1;
        win_idx   = 5'(i);
      end
    end
  end

  always_comb begin
    claim_mask = '0;
    for (int i = 0; i < NUM_SRC; i++)
      claim_mask[i] = take && (win_idx == 5'(i));
  end

  // A fresh edge outranks both software clear and claim clear; level sources follow the line.
  always_comb begin
    pending_next = (pending & ~w1c_mask & ~claim_mask) | edge_hit;
    for (int i = 0; i < NUM_SRC; i++)
      if (mode[i])
        pending_next[i] = sync2[i];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      enable  <= '0;
    end else begin
      pending <= pending_next;
      if (wr && (offset == 3'd1))
        enable <= (enable & ~lane_mask[NUM_SRC-1:0]) | wmask;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (win_valid) next_state = REQ;
      REQ: begin
        if (!win_valid)
          next_state = IDLE;
        else if (IACK)
          next_state = ACKLOW;
      end
      ACKLOW:  if (!IACK) next_state = SERVICE;
      SERVICE: if (eoi) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      I_Req  <= 1'b0;
      irq_id <= '0;
    end else begin
      state <= next_state;
      I_Req <= (next_state == REQ);
      if (take)
        irq_id <= win_idx;
      else if ((state == SERVICE) && eoi)
        irq_id <= '0;
    end
  end

  assign claim_word = ((state == ACKLOW) || (state == SERVICE)) ? {27'b0, irq_id} : 32'hFFFF_FFFF;

  always_comb begin
    Rdata = '0;
    if (sel) begin
      case (offset)
        3'd0:    Rdata = 32'(pending);
        3'd1:    Rdata = 32'(enable);
        3'd2:    Rdata = claim_word;
        3'd4:    Rdata = mode_word;
        default: Rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller (default edge-only build) with a timeline-based reference model.
module tb_irq_controller;

  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk, reset, IACK, sel, I_Req;
  logic [7:0]  irq_src;
  logic [31:0] Data_addr, Wdata, Rdata;
  logic [3:0]  we;
  logic [4:0]  irq_id;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_pend, m_en;
  logic       m_req;
  logic [7:0] hist[$];

  irq_controller #(.NUM_SRC(8), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .irq_src(irq_src), .Data_addr(Data_addr), .Wdata(Wdata),
    .we(we), .Rdata(Rdata), .sel(sel), .I_Req(I_Req), .IACK(IACK), .irq_id(irq_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The model advances one edge: a rise seen 3 samples ago (after a low 4 ago) lands in PENDING now.
  task automatic step();
    logic [31:0] lm;
    logic [7:0]  wm, rise;
    logic        wr;
    lm = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
    wm = Wdata[7:0] & lm[7:0];
    wr = (Data_addr[31:5] == BASE[31:5]) && (we != 4'b0000);
    m_req = |(m_pend & m_en);
    hist.push_front(irq_src);
    rise = hist[3] & ~hist[4];
    void'(hist.pop_back());
    if (wr && Data_addr[4:2] == 3'd0) m_pend = m_pend & ~wm;
    m_pend = m_pend | rise;
    if (wr && Data_addr[4:2] == 3'd1) m_en = (m_en & ~lm[7:0]) | wm;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [4:0] off, input logic [31:0] d, input logic [3:0] be);
    Data_addr = BASE + 32'(off);
    Wdata     = d;
    we        = be;
    step();
    we        = 4'b0000;
  endtask

  task automatic bus_read(input logic [4:0] off, output logic [31:0] d);
    Data_addr = BASE + 32'(off);
    #1;
    d = Rdata;
  endtask

  task automatic do_reset();
    reset = 1'b0; irq_src = '0; IACK = 1'b0; we = '0; Wdata = '0; Data_addr = BASE;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    m_pend = '0; m_en = '0; m_req = 1'b0;
    hist = '{8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    do_reset();
    n_checks++; if (I_Req !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ireq got %b want 0", I_Req); end
    n_checks++; if (irq_id !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_id got %0d want 0", irq_id); end
    bus_read(5'h00, r);
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_pending got %h want 0", r); end
    bus_read(5'h04, r);
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_enable got %h want 0", r); end
    bus_read(5'h08, r);
    n_checks++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("[TB] FAIL reset_claim got %h want ffffffff", r); end
    bus_read(5'h10, r);
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_mode got %h want 0", r); end
    n_checks++; if (sel !== 1'b1) begin n_fail++; $display("[TB] FAIL sel_in got %b want 1", sel); end
    Data_addr = 32'h0000_1004;
    #1;
    n_checks++; if (sel !== 1'b0 || Rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL sel_out got %b/%h want 0/0", sel, Rdata); end
  endtask

  task automatic test_edge_to_request();
    logic [31:0] r;
    do_reset();
    bus_write(5'h04, 32'h04, 4'b1111);
    irq_src = 8'h04; step(); irq_src = 8'h00;
    step(); step();
    bus_read(5'h00, r);
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("[TB] FAIL e2r_pend_early got %h want 0", r); end
    step();
    bus_read(5'h00, r);
    n_checks++; if (r !== 32'h04 || I_Req !== 1'b0) begin n_fail++; $display("[TB] FAIL e2r_pend got %h/%b want 04/0", r, I_Req); end
    step();
    n_checks++; if (I_Req !== 1'b1) begin n_fail++; $display("[TB] FAIL e2r_ireq got %b want 1", I_Req); end
    IACK = 1'b1; step(); IACK = 1'b0;
    bus_read(5'h08, r);
    n_checks++; if (r !== 32'd2 || irq_id !== 5'd2) begin n_fail++; $display("[TB] FAIL e2r_claim got %h/%0d want 2", r, irq_id); end
    bus_read(5'h00, r);
    n_checks++; if (r !== 32'h0 || I_Req !== 1'b0) begin n_fail++; $display("[TB] FAIL e2r_after_ack got %h/%b want 0/0", r, I_Req); end
    step();
    bus_write(5'h0C, 32'h0, 4'b1111);
    bus_read(5'h08, r);
    n_checks++; if (r !== 32'hFFFF_FFFF || irq_id !== 5'd0) begin n_fail++; $display("[TB] FAIL e2r_eoi got %h/%0d want ffffffff/0", r, irq_id); end
  endtask

  task automatic test_priority();
    logic [31:0] r;
    do_reset();
    bus_write(5'h04, 32'hFF, 4'b0001);
    irq_src = 8'h22; step(); irq_src = 8'h00;
    repeat (4) step();
    IACK = 1'b1; step(); IACK = 1'b0;
    bus_read(5'h08, r);
    n_checks++; if (r !== 32'd1) begin n_fail++; $display("[TB] FAIL prio_first got %h want 1", r); end
    step();
    bus_write(5'h0C, 32'h1, 4'b0001);
    step();
    n_checks++; if (I_Req !== 1'b1) begin n_fail++; $display("[TB] FAIL prio_rereq got %b want 1", I_Req); end
    IACK = 1'b1; step(); IACK = 1'b0;
    bus_read(5'h08, r);
    n_checks++; if (r !== 32'd5) begin n_fail++; $display("[TB] FAIL prio_second got %h want 5", r); end
    step();
    bus_write(5'h0C, 32'h1, 4'b0001);
  endtask

  task automatic test_stalled_ack();
    logic [31:0] r;
    int bad;
    do_reset();
    bus_write(5'h04, 32'h08, 4'b0001);
    irq_src = 8'h08; step(); irq_src = 8'h00;
    repeat (4) step();
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      bus_read(5'h08, r);
      if (I_Req !== 1'b1 || r !== 32'hFFFF_FFFF) bad++;
      step();
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("[TB] FAIL stall_hold got %0d bad cycles want 0", bad); end
    IACK = 1'b1; step(); IACK = 1'b0;
    bus_read(5'h08, r);
    n_checks++; if (r !== 32'd3 || I_Req !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_claim got %h/%b want 3/0", r, I_Req); end
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      bus_read(5'h08, r);
      if (I_Req !== 1'b0 || r !== 32'd3) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("[TB] FAIL stall_single got %0d bad cycles want 0", bad); end
    bus_write(5'h0C, 32'h0, 4'b1000);
  endtask

  task automatic test_byte_w1c();
    logic [31:0] r;
    do_reset();
    bus_write(5'h04, 32'h0000_FF00, 4'b0010);
    bus_read(5'h04, r);
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("[TB] FAIL byte_lane1 got %h want 0", r); end
    bus_write(5'h04, 32'h1234_56A5, 4'b0001);
    bus_read(5'h04, r);
    n_checks++; if (r !== 32'hA5) begin n_fail++; $display("[TB] FAIL byte_lane0 got %h want a5", r); end
    bus_write(5'h04, 32'h0, 4'b1111);
    irq_src = 8'h01; step();
    irq_src = 8'h00; step();
    irq_src = 8'h01; step();
    irq_src = 8'h00; step();
    bus_read(5'h00, r);
    n_checks++; if (r !== 32'h01) begin n_fail++; $display("[TB] FAIL w1c_first got %h want 01", r); end
    step();
    bus_write(5'h00, 32'h01, 4'b1111);
    bus_read(5'h00, r);
    n_checks++; if (r !== 32'h01) begin n_fail++; $display("[TB] FAIL w1c_vs_edge got %h want 01", r); end
    bus_write(5'h00, 32'h01, 4'b0001);
    bus_read(5'h00, r);
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("[TB] FAIL w1c_clear got %h want 0", r); end
  endtask

  task automatic test_disable_req();
    logic [31:0] r;
    do_reset();
    bus_write(5'h04, 32'h08, 4'b0001);
    irq_src = 8'h08; step(); irq_src = 8'h00;
    repeat (4) step();
    n_checks++; if (I_Req !== 1'b1) begin n_fail++; $display("[TB] FAIL dis_req got %b want 1", I_Req); end
    bus_write(5'h04, 32'h0, 4'b0001);
    step();
    bus_read(5'h00, r);
    n_checks++; if (I_Req !== 1'b0 || r !== 32'h08) begin n_fail++; $display("[TB] FAIL dis_drop got %b/%h want 0/08", I_Req, r); end
    repeat (3) step();
    bus_read(5'h08, r);
    n_checks++; if (I_Req !== 1'b0 || r !== 32'hFFFF_FFFF) begin n_fail++; $display("[TB] FAIL dis_idle got %b/%h want 0/ffffffff", I_Req, r); end
  endtask

  task automatic test_async_reset();
    logic [31:0] r;
    do_reset();
    bus_write(5'h04, 32'h01, 4'b0001);
    irq_src = 8'h01; step(); irq_src = 8'h00;
    repeat (4) step();
    IACK = 1'b1; step(); IACK = 1'b0;
    step();
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (I_Req !== 1'b0 || irq_id !== 5'd0) begin n_fail++; $display("[TB] FAIL arst_out got %b/%0d want 0/0", I_Req, irq_id); end
    bus_read(5'h08, r);
    n_checks++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("[TB] FAIL arst_claim got %h want ffffffff", r); end
    bus_read(5'h04, r);
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("[TB] FAIL arst_enable got %h want 0", r); end
    do_reset();
  endtask

  task automatic test_random();
    logic [31:0] r;
    int bad_p, bad_e, bad_q, bad_z;
    do_reset();
    bad_p = 0; bad_e = 0; bad_q = 0; bad_z = 0;
    for (int c = 0; c < 400; c++) begin
      irq_src = 8'($urandom);
      case ($urandom_range(0, 3))
        0: begin Data_addr = BASE + 32'h4; Wdata = $urandom; we = 4'($urandom); end
        1: begin Data_addr = BASE; Wdata = $urandom; we = 4'($urandom); end
        2: begin Data_addr = BASE + 32'h14; Wdata = $urandom; we = 4'b1111; end
        default: begin Data_addr = BASE; we = 4'b0000; end
      endcase
      step();
      we = 4'b0000;
      if (I_Req !== m_req) bad_q++;
      bus_read(5'h00, r);
      if (r !== 32'(m_pend)) bad_p++;
      bus_read(5'h04, r);
      if (r !== 32'(m_en)) bad_e++;
      bus_read(5'h14, r);
      if (r !== 32'h0) bad_z++;
    end
    n_checks++; if (bad_q !== 0) begin n_fail++; $display("[TB] FAIL rand_ireq got %0d bad cycles want 0", bad_q); end
    n_checks++; if (bad_p !== 0) begin n_fail++; $display("[TB] FAIL rand_pending got %0d bad cycles want 0", bad_p); end
    n_checks++; if (bad_e !== 0) begin n_fail++; $display("[TB] FAIL rand_enable got %0d bad cycles want 0", bad_e); end
    n_checks++; if (bad_z !== 0) begin n_fail++; $display("[TB] FAIL rand_reserved got %0d bad cycles want 0", bad_z); end
  endtask

  initial begin
    test_reset();
    test_edge_to_request();
    test_priority();
    test_stalled_ack();
    test_byte_w1c();
    test_disable_req();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
